// File: rtl/vga_timing.sv
// 640x480@60 VGA raster timing: divides the system clock to the pixel rate and
// produces pixel counters, active-video flag and active-low sync pulses.
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       bright,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_en,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic       tick;
  logic [9:0] hcount_reg, hcount_next;
  logic [9:0] vcount_reg, vcount_next;
  logic       bright_reg, hsync_reg, vsync_reg;
  logic       pix_en_reg, line_start_reg, frame_start_reg;

  // Pixel-rate divider; with CLK_DIV=1 every enabled clock is a pixel.
  generate
    if (CLK_DIV == 1) begin : g_nodiv
      assign tick = en;
    end else begin : g_div
      localparam int DIV_W = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

      logic [DIV_W-1:0] div_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          div_reg <= '0;
        end else if (en) begin
          div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
        end
      end

      assign tick = en && (div_reg == DIV_LAST);
    end
  endgenerate

  always_comb begin
    hcount_next = hcount_reg + 10'd1;
    vcount_next = vcount_reg;
    if (hcount_reg == H_LAST) begin
      hcount_next = '0;
      vcount_next = (vcount_reg == V_LAST) ? '0 : vcount_reg + 10'd1;
    end
  end

  // Reset parks on the last blanked pixel so the first tick lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_reg      <= H_LAST;
      vcount_reg      <= V_LAST;
      bright_reg      <= 1'b0;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      pix_en_reg      <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      pix_en_reg      <= tick;
      line_start_reg  <= tick && (hcount_next == 10'd0);
      frame_start_reg <= tick && (hcount_next == 10'd0) && (vcount_next == 10'd0);
      if (tick) begin
        hcount_reg <= hcount_next;
        vcount_reg <= vcount_next;
        // Decode the new position so flags never lag the counters.
        bright_reg <= (hcount_next < H_VIS) && (vcount_next < V_VIS);
        hsync_reg  <= !((hcount_next >= HS_START) && (hcount_next < HS_END));
        vsync_reg  <= !((vcount_next >= VS_START) && (vcount_next < VS_END));
      end
    end
  end

  assign hcount      = hcount_reg;
  assign vcount      = vcount_reg;
  assign bright      = bright_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign pix_en      = pix_en_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule
